// File: rtl/axicb_pkg.sv
// rtl/axicb_pkg.sv - shared constants, types and helpers for the crossbar write scheduler
package axicb_pkg;

    // Largest master count any crossbar slave agent is built with.
    localparam int AXICB_MST_NB_MAX = 8;

    typedef enum logic {
        AW_IDLE   = 1'b0,
        AW_LOCKED = 1'b1
    } aw_state_t;

    // Index of the set bit in a one-hot vector; 0 for an all-zero vector.
    function automatic logic [2:0] onehot_to_idx(input logic [AXICB_MST_NB_MAX-1:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < AXICB_MST_NB_MAX; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/axicb_scfifo.sv
// rtl/axicb_scfifo.sv - single-clock FIFO with occupancy count and optional pass-through
// Ports:
//   aclk, arst (async, active-high), srst (sync)
//   push/push_data in : write side (ignored when full)
//   pop/pop_data       : read side (pop ignored when empty)
//   full, empty, count : status, full/count taken from the registered occupancy
module axicb_scfifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int PASS_THRU = 0,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = AW + 1
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;
    logic             stored_empty;

    assign full         = (count == CW'(DEPTH));
    assign stored_empty = (count == '0);
    assign wr_en        = push && !full;

    generate
        if (PASS_THRU != 0) begin : g_pass
            // An empty FIFO presents the incoming word directly at its head.
            assign pop_data = stored_empty ? push_data : mem[rd_ptr];
            assign empty    = stored_empty && !push;
        end else begin : g_reg
            assign pop_data = mem[rd_ptr];
            assign empty    = stored_empty;
        end
    endgenerate

    assign rd_en = pop && !empty;

    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (srst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axicb_wsched_rr.sv
// rtl/axicb_wsched_rr.sv - combinational round-robin candidate selector
// Ports:
//   req    in  MST_NB   : request vector (one bit per master)
//   rr_ptr in  IW       : highest-priority master index
//   cand   out MST_NB   : one-hot first requester at or above rr_ptr, wrapping; 0 if none
module axicb_wsched_rr #(
    parameter int MST_NB = 4,
    localparam int IW    = $clog2(MST_NB)
) (
    input  logic [MST_NB-1:0] req,
    input  logic [IW-1:0]     rr_ptr,
    output logic [MST_NB-1:0] cand
);

    logic found;
    int   j;

    always_comb begin
        cand  = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < MST_NB; k++) begin
            j = (int'(rr_ptr) + k) % MST_NB;
            if (!found && req[j]) begin
                cand[j] = 1'b1;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axicb_wr_sched.sv
// rtl/axicb_wr_sched.sv - AW round-robin arbiter and in-order W steering for one slave agent
// Optional feature: AXICB_WSCHED_BYPASS_EN lets W be steered in the AW handshake cycle
// when no burst is outstanding.
// Ports:
//   aclk, arst (async, active-high), srst (sync, same effect)
//   i_awvalid/i_awready [MST_NB], o_awvalid/o_awready, aw_grant [MST_NB] : AW side
//   i_wvalid/i_wlast/i_wready [MST_NB], o_wvalid/o_wready, w_grant [MST_NB] : W side
//   ostd_cnt : order-FIFO occupancy
module axicb_wr_sched
    import axicb_pkg::*;
#(
    parameter int MST_NB     = 4,
    parameter int OSTD_DEPTH = 8,
    localparam int IW        = $clog2(MST_NB),
    localparam int CW        = $clog2(OSTD_DEPTH) + 1
) (
    input  logic              aclk,
    input  logic              arst,
    input  logic              srst,
    input  logic [MST_NB-1:0] i_awvalid,
    output logic [MST_NB-1:0] i_awready,
    output logic              o_awvalid,
    input  logic              o_awready,
    output logic [MST_NB-1:0] aw_grant,
    input  logic [MST_NB-1:0] i_wvalid,
    input  logic [MST_NB-1:0] i_wlast,
    output logic [MST_NB-1:0] i_wready,
    output logic              o_wvalid,
    input  logic              o_wready,
    output logic [MST_NB-1:0] w_grant,
    output logic [CW-1:0]     ostd_cnt
);

    aw_state_t                   state;
    aw_state_t                   state_nxt;
    logic [IW-1:0]               rr_ptr;
    logic [IW-1:0]               lock_idx;
    logic [IW-1:0]               awg_idx;
    logic [MST_NB-1:0]           cand;
    logic [MST_NB-1:0]           aw_grant_raw;
    logic [MST_NB-1:0]           w_grant_raw;
    logic [AXICB_MST_NB_MAX-1:0] awg_ext;
    logic                        rst_any;
    logic                        aw_hs;
    logic                        w_last_hs;
    logic                        fifo_push;
    logic                        fifo_pop;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [MST_NB-1:0]           fifo_head;
    logic [CW-1:0]               fifo_cnt;

    // Outputs are forced quiet while either reset is asserted, so a reset
    // mid-burst never lets a stray beat or request through.
    assign rst_any = arst || srst;

    axicb_wsched_rr #(.MST_NB(MST_NB)) u_rr (
        .req    (i_awvalid),
        .rr_ptr (rr_ptr),
        .cand   (cand)
    );

    assign aw_grant_raw = (state == AW_LOCKED) ? (MST_NB'(1) << lock_idx) : cand;
    assign aw_grant     = rst_any ? '0 : aw_grant_raw;
    assign o_awvalid    = (|(aw_grant & i_awvalid)) && !fifo_full;
    assign i_awready    = aw_grant & {MST_NB{o_awready && !fifo_full}};
    assign aw_hs        = o_awvalid && o_awready;

    always_comb begin
        awg_ext                = '0;
        awg_ext[MST_NB-1:0]    = aw_grant;
    end
    assign awg_idx = IW'(onehot_to_idx(awg_ext));

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state <= AW_IDLE;
        end else if (srst) begin
            state <= AW_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            AW_IDLE:   if (o_awvalid && !o_awready) state_nxt = AW_LOCKED;
            AW_LOCKED: if (aw_hs)                   state_nxt = AW_IDLE;
            default:   state_nxt = AW_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else if (srst) begin
            rr_ptr   <= '0;
            lock_idx <= '0;
        end else begin
            if (state == AW_IDLE && state_nxt == AW_LOCKED) begin
                lock_idx <= awg_idx;
            end
            if (aw_hs) begin
                rr_ptr <= (awg_idx == IW'(MST_NB - 1)) ? '0 : awg_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_grant_raw = fifo_empty ? '0 : fifo_head;
`ifdef AXICB_WSCHED_BYPASS_EN
        if (fifo_empty && aw_hs) begin
            w_grant_raw = aw_grant;
        end
`endif
    end

    assign w_grant   = rst_any ? '0 : w_grant_raw;
    assign o_wvalid  = |(w_grant & i_wvalid);
    assign i_wready  = w_grant & {MST_NB{o_wready}};
    assign w_last_hs = o_wvalid && o_wready && (|(w_grant & i_wlast));
    assign fifo_pop  = w_last_hs && !fifo_empty;

`ifdef AXICB_WSCHED_BYPASS_EN
    // A single-beat burst completed through the bypass never needs an entry.
    assign fifo_push = aw_hs && !(fifo_empty && w_last_hs);
`else
    assign fifo_push = aw_hs;
`endif

    axicb_scfifo #(
        .WIDTH     (MST_NB),
        .DEPTH     (OSTD_DEPTH),
        .PASS_THRU (0)
    ) u_order_fifo (
        .aclk      (aclk),
        .arst      (arst),
        .srst      (srst),
        .push      (fifo_push),
        .push_data (aw_grant),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

    assign ostd_cnt = rst_any ? '0 : fifo_cnt;

endmodule

// File: tb/tb_axicb_wr_sched.sv
// tb/tb_axicb_wr_sched.sv - self-checking bench for axicb_wr_sched against a queue-based model
module tb_axicb_wr_sched;

    localparam int N     = 4;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;
`ifdef AXICB_WSCHED_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          aclk = 1'b0;
    logic          arst, srst;
    logic [N-1:0]  i_awvalid, i_awready, aw_grant;
    logic          o_awvalid, o_awready;
    logic [N-1:0]  i_wvalid, i_wlast, i_wready, w_grant;
    logic          o_wvalid, o_wready;
    logic [CW-1:0] ostd_cnt;

    axicb_wr_sched #(.MST_NB(N), .OSTD_DEPTH(DEPTH)) dut (
        .aclk(aclk), .arst(arst), .srst(srst),
        .i_awvalid(i_awvalid), .i_awready(i_awready),
        .o_awvalid(o_awvalid), .o_awready(o_awready), .aw_grant(aw_grant),
        .i_wvalid(i_wvalid), .i_wlast(i_wlast), .i_wready(i_wready),
        .o_wvalid(o_wvalid), .o_wready(o_wready), .w_grant(w_grant),
        .ostd_cnt(ostd_cnt)
    );

    always #5 aclk = ~aclk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: round-robin pointer, locked master (-1 = none), and
    // the queue of granted master indices awaiting their W burst.
    int m_rr   = 0;
    int m_lock = -1;
    int m_q[$];

    // Observations taken at the last step's sampling point.
    logic [N-1:0]  s_awg, s_awr, s_wg, s_wr;
    logic          s_awv, s_wv;
    logic [CW-1:0] s_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: inputs are already applied; sample mid-cycle, compare
    // against the model, then advance the model across the rising edge.
    task automatic step();
        int ag, wg;
        bit rst, full, aw_hs, last_hs, byp_done;
        logic [N-1:0] e_awg, e_awr, e_wg, e_wr;
        logic e_awv, e_wv;
        int e_cnt;
        #4;
        rst = arst || srst;
        ag  = -1;
        wg  = -1;
        full = (m_q.size() >= DEPTH);
        if (!rst) begin
            if (m_lock >= 0) ag = m_lock;
            else for (int k = 0; k < N; k++) begin
                if (ag < 0 && i_awvalid[(m_rr + k) % N]) ag = (m_rr + k) % N;
            end
        end
        e_awg = (ag >= 0) ? N'(1) << ag : '0;
        e_awv = (ag >= 0) && i_awvalid[ag] && !full;
        e_awr = (ag >= 0 && o_awready && !full) ? e_awg : '0;
        aw_hs = e_awv && o_awready;
        if (!rst) begin
            if (m_q.size() > 0) wg = m_q[0];
            else if (BYP && aw_hs) wg = ag;
        end
        e_wg    = (wg >= 0) ? N'(1) << wg : '0;
        e_wv    = (wg >= 0) && i_wvalid[wg];
        e_wr    = (wg >= 0 && o_wready) ? e_wg : '0;
        last_hs = e_wv && o_wready && i_wlast[wg];
        e_cnt   = rst ? 0 : m_q.size();

        s_awg = aw_grant; s_awr = i_awready; s_awv = o_awvalid;
        s_wg  = w_grant;  s_wr  = i_wready;  s_wv  = o_wvalid; s_cnt = ostd_cnt;
        chk("aw_grant",  32'(aw_grant),  32'(e_awg));
        chk("o_awvalid", 32'(o_awvalid), 32'(e_awv));
        chk("i_awready", 32'(i_awready), 32'(e_awr));
        chk("w_grant",   32'(w_grant),   32'(e_wg));
        chk("o_wvalid",  32'(o_wvalid),  32'(e_wv));
        chk("i_wready",  32'(i_wready),  32'(e_wr));
        chk("ostd_cnt",  32'(ostd_cnt),  32'(e_cnt));

        @(posedge aclk);
        #1;
        if (rst) begin
            m_rr = 0; m_lock = -1; m_q.delete();
        end else begin
            byp_done = (m_q.size() == 0) && last_hs;
            if (last_hs && m_q.size() > 0) void'(m_q.pop_front());
            if (aw_hs) begin
                m_rr   = (ag + 1) % N;
                m_lock = -1;
                if (!byp_done) m_q.push_back(ag);
            end else if (e_awv) begin
                m_lock = ag;
            end
        end
    endtask

    task automatic idle_inputs();
        i_awvalid = '0; o_awready = 1'b0;
        i_wvalid  = '0; i_wlast   = '0; o_wready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        arst = 1'b1;
        step();
        arst = 1'b0;
    endtask

    initial begin
        arst = 1'b1; srst = 1'b0;
        idle_inputs();
        @(posedge aclk);
        #1;

        // Reset state
        step();
        chk("rst_aw_grant", 32'(s_awg), 32'h0);
        chk("rst_ostd_cnt", 32'(s_cnt), 32'h0);
        arst = 1'b0;

        // Round-robin with every master requesting; single-beat W drains the queue
        i_awvalid = 4'b1111; o_awready = 1'b1;
        i_wvalid  = 4'b1111; i_wlast = 4'b1111; o_wready = 1'b1;
        step(); chk("rr_0", 32'(s_awg), 32'h1);
        step(); chk("rr_1", 32'(s_awg), 32'h2);
        step(); chk("rr_2", 32'(s_awg), 32'h4);
        step(); chk("rr_3", 32'(s_awg), 32'h8);
        step(); chk("rr_4", 32'(s_awg), 32'h1);

        // Lock held while slave stalls, even as master 0 joins
        do_reset();
        i_awvalid = 4'b0010;
        step(); chk("lock_start", 32'(s_awg), 32'h2);
        i_awvalid = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            step(); chk("lock_hold", 32'(s_awg), 32'h2);
        end
        o_awready = 1'b1;
        step(); chk("lock_hs", 32'(s_awr), 32'h2);
        i_awvalid = 4'b0101;
        step(); chk("lock_next", 32'(s_awg), 32'h4);

        // W order follows AW order: master 2 first, then master 0
        do_reset();
        o_awready = 1'b1;
        i_awvalid = 4'b0100; step();
        i_awvalid = 4'b0001; step();
        i_awvalid = 4'b0000; o_awready = 1'b0;
        i_wvalid = 4'b0101; o_wready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            i_wlast = (b == 3) ? 4'b0101 : 4'b0001;
            step();
            chk("order_m0_blocked", 32'(s_wr[0]), 32'h0);
            chk("order_m2_grant", 32'(s_wg), 32'h4);
        end
        i_wlast = 4'b0001; i_wvalid = 4'b0001;
        step(); chk("order_next", 32'(s_wg), 32'h1);

        // Full order FIFO blocks a third AW until a pop has registered
        do_reset();
        o_awready = 1'b1;
        i_awvalid = 4'b0001; step();
        i_awvalid = 4'b0010; step();
        i_awvalid = 4'b0100;
        step();
        chk("full_awvalid", 32'(s_awv), 32'h0);
        chk("full_awready", 32'(s_awr), 32'h0);
        chk("full_cnt", 32'(s_cnt), 32'h2);
        i_wvalid = 4'b0001; i_wlast = 4'b0001; o_wready = 1'b1;
        step(); chk("full_pop_same", 32'(s_awv), 32'h0);
        i_wvalid = '0;
        step(); chk("full_after_pop", 32'(s_awr), 32'h4);

        // Asynchronous reset during beat 2 of a 4-beat burst
        do_reset();
        o_awready = 1'b1; i_awvalid = 4'b0010; step();
        i_awvalid = '0; i_wvalid = 4'b0010; i_wlast = '0; o_wready = 1'b1;
        step();
        arst = 1'b1;
        step();
        chk("rst_mid_wready", 32'(s_wr), 32'h0);
        chk("rst_mid_wgrant", 32'(s_wg), 32'h0);
        chk("rst_mid_cnt", 32'(s_cnt), 32'h0);
        arst = 1'b0;
        i_wvalid = '0; i_awvalid = 4'b1111; o_awready = 1'b0;
        step(); chk("rst_mid_rr", 32'(s_awg), 32'h1);

        // Single-beat W arriving together with its AW
        do_reset();
        i_awvalid = 4'b0001; o_awready = 1'b1;
        i_wvalid = 4'b0001; i_wlast = 4'b0001; o_wready = 1'b1;
        step(); chk("byp_same_cycle", 32'(s_wr), BYP ? 32'h1 : 32'h0);
        i_awvalid = '0;
        step();
        chk("byp_cnt", 32'(s_cnt), BYP ? 32'h0 : 32'h1);
        chk("byp_next_cycle", 32'(s_wr), BYP ? 32'h0 : 32'h1);

        // Randomized traffic, including occasional synchronous and asynchronous resets
        do_reset();
        for (int c = 0; c < 600; c++) begin
            i_awvalid = N'($urandom);
            o_awready = ($urandom_range(0, 2) != 0);
            i_wvalid  = N'($urandom);
            i_wlast   = N'($urandom);
            o_wready  = ($urandom_range(0, 3) != 0);
            srst      = ($urandom_range(0, 49) == 0);
            arst      = ($urandom_range(0, 79) == 0);
            step();
        end
        arst = 1'b0; srst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
